// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 definitions: decoder state, prefix/status byte values and
// 9-bit {ext,code} key identifiers used by the downstream key handler stages.
package ps2_pkg;

    // Decoder states for the prefix parser
    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StSkip
    } ps2_state_e;

    // Prefix and keyboard status bytes
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ACK   = 8'hFA;
    localparam logic [7:0] PS2_ECHO  = 8'hEE;
    localparam logic [7:0] PS2_ERR0  = 8'h00;
    localparam logic [7:0] PS2_BATF1 = 8'hFC;
    localparam logic [7:0] PS2_BATF2 = 8'hFD;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERRF  = 8'hFF;

    // Shift codes the keyboard injects around extended keys (E0 12 / E0 59)
    localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

    // Bytes that follow the E1 of the Pause sequence
    localparam int unsigned PAUSE_TAIL = 7;

    // 9-bit key codes {ext, code}
    localparam logic [8:0] KC_0     = 9'h045;
    localparam logic [8:0] KC_1     = 9'h016;
    localparam logic [8:0] KC_2     = 9'h01E;
    localparam logic [8:0] KC_3     = 9'h026;
    localparam logic [8:0] KC_4     = 9'h025;
    localparam logic [8:0] KC_5     = 9'h02E;
    localparam logic [8:0] KC_6     = 9'h036;
    localparam logic [8:0] KC_7     = 9'h03D;
    localparam logic [8:0] KC_8     = 9'h03E;
    localparam logic [8:0] KC_9     = 9'h046;
    localparam logic [8:0] KC_KP0   = 9'h070;
    localparam logic [8:0] KC_KP1   = 9'h069;
    localparam logic [8:0] KC_KP2   = 9'h072;
    localparam logic [8:0] KC_KP3   = 9'h07A;
    localparam logic [8:0] KC_KP4   = 9'h06B;
    localparam logic [8:0] KC_KP5   = 9'h073;
    localparam logic [8:0] KC_KP6   = 9'h074;
    localparam logic [8:0] KC_KP7   = 9'h06C;
    localparam logic [8:0] KC_KP8   = 9'h075;
    localparam logic [8:0] KC_KP9   = 9'h07D;
    localparam logic [8:0] KC_ENTER = 9'h05A;
    localparam logic [8:0] KC_KPENT = 9'h15A;
    localparam logic [8:0] KC_BKSP  = 9'h066;
    localparam logic [8:0] KC_ESC   = 9'h076;
    localparam logic [8:0] KC_UP    = 9'h175;
    localparam logic [8:0] KC_DOWN  = 9'h172;
    localparam logic [8:0] KC_LEFT  = 9'h16B;
    localparam logic [8:0] KC_RIGHT = 9'h174;

    // Keyboard status/response bytes that never describe a key
    function automatic logic is_status_byte(input logic [7:0] b);
        logic res;
        case (b)
            PS2_ERR0, PS2_BAT, PS2_ECHO, PS2_ACK,
            PS2_BATF1, PS2_BATF2, PS2_RESEND, PS2_ERRF: res = 1'b1;
            default:                                    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ps2_seq_timeout.sv
// Idle-clock watchdog for partially received scan-code sequences.
// Counts while enabled, clears on request, flags expiry on the last allowed idle clock.
module ps2_seq_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned TO_W           = 21
) (
    input  logic clk,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // A clear in the same cycle (a byte arrived) overrides expiry
    assign expire = en && !clr && (to_cnt == LAST);

    // Idle counter: held at zero unless enabled and not being cleared
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            to_cnt <= '0;
        end else if (clr || !en || expire) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: turns the received byte stream into a held-key
// bitmap indexed by {ext,code}, with a one-cycle change strobe and an abort strobe
// for sequences dropped by timeout or receive error.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter bit          REPEAT_EN      = 1'b0,
    parameter int unsigned TO_W           = 21
) (
    input  logic         clk,
    input  logic         RST,
    input  logic [7:0]   rx_byte,
    input  logic         rx_valid,
    input  logic         rx_err,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         been_ready,
    output logic         seq_abort
);

    ps2_state_e   state_q, state_d;
    logic [2:0]   skip_cnt_q, skip_cnt_d;
    logic [511:0] key_down_q, key_down_d;
    logic [8:0]   last_change_q, last_change_d;
    logic         been_ready_q, been_ready_d;
    logic         seq_abort_q, seq_abort_d;

    logic         to_expire;
    logic         key_ev;
    logic         key_brk;
    logic [8:0]   key_code;

    ps2_seq_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk    (clk),
        .RST    (RST),
        .clr    (rx_valid || rx_err),
        .en     (state_q != StIdle),
        .expire (to_expire)
    );

    // Prefix parser: next state and the key event (if any) carried by this byte
    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        seq_abort_d = 1'b0;
        key_ev      = 1'b0;
        key_brk     = 1'b0;
        key_code    = '0;

        if (rx_err) begin
            // Corrupt byte: drop whatever was in flight
            state_d     = StIdle;
            skip_cnt_d  = '0;
            seq_abort_d = (state_q != StIdle);
        end else if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_byte == PS2_EXT) begin
                        state_d = StExt;
                    end else if (rx_byte == PS2_BRK) begin
                        state_d = StBrk;
                    end else if (rx_byte == PS2_PAUSE) begin
                        state_d    = StSkip;
                        skip_cnt_d = 3'(PAUSE_TAIL);
                    end else if (!is_status_byte(rx_byte)) begin
                        key_ev   = 1'b1;
                        key_code = {1'b0, rx_byte};
                    end
                end
                StExt: begin
                    if (rx_byte == PS2_BRK) begin
                        state_d = StExtBrk;
                    end else begin
                        state_d = StIdle;
                        if (rx_byte != PS2_FAKE_LSHIFT && rx_byte != PS2_FAKE_RSHIFT) begin
                            key_ev   = 1'b1;
                            key_code = {1'b1, rx_byte};
                        end
                    end
                end
                StBrk: begin
                    state_d  = StIdle;
                    key_ev   = 1'b1;
                    key_brk  = 1'b1;
                    key_code = {1'b0, rx_byte};
                end
                StExtBrk: begin
                    state_d  = StIdle;
                    key_ev   = 1'b1;
                    key_brk  = 1'b1;
                    key_code = {1'b1, rx_byte};
                end
                StSkip: begin
                    // Pause carries no break; just count its tail bytes away
                    if (skip_cnt_q <= 3'd1) begin
                        state_d    = StIdle;
                        skip_cnt_d = '0;
                    end else begin
                        skip_cnt_d = skip_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    skip_cnt_d = '0;
                end
            endcase
        end else if (to_expire) begin
            state_d     = StIdle;
            skip_cnt_d  = '0;
            seq_abort_d = 1'b1;
        end
    end

    // Bitmap update: breaks always strobe, repeated makes strobe only with REPEAT_EN
    always_comb begin
        key_down_d    = key_down_q;
        last_change_d = last_change_q;
        been_ready_d  = 1'b0;

        if (key_ev) begin
            if (key_brk) begin
                key_down_d[key_code] = 1'b0;
                last_change_d        = key_code;
                been_ready_d         = 1'b1;
            end else if (!key_down_q[key_code] || REPEAT_EN) begin
                key_down_d[key_code] = 1'b1;
                last_change_d        = key_code;
                been_ready_d         = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q       <= StIdle;
            skip_cnt_q    <= '0;
            key_down_q    <= '0;
            last_change_q <= '0;
            been_ready_q  <= 1'b0;
            seq_abort_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            key_down_q    <= key_down_d;
            last_change_q <= last_change_d;
            been_ready_q  <= been_ready_d;
            seq_abort_q   <= seq_abort_d;
        end
    end

    assign key_down    = key_down_q;
    assign last_change = last_change_q;
    assign been_ready  = been_ready_q;
    assign seq_abort   = seq_abort_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: two instances (repeat suppressed / enabled) share one
// byte stream; every cycle is compared with a behavioural model, plus a directed
// vector table and hand-written timeout / error / async-reset sequences.
module tb_ps2_scan_decoder;

    localparam int unsigned TO = 20;

    logic         clk = 1'b0;
    logic         RST = 1'b1;
    logic [7:0]   rx_byte = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_err = 1'b0;

    logic [511:0] kd0, kd1;
    logic [8:0]   lc0, lc1;
    logic         br0, br1, ab0, ab1;

    ps2_scan_decoder #(.TIMEOUT_CYCLES(TO), .REPEAT_EN(1'b0), .TO_W(5)) dut0 (
        .clk(clk), .RST(RST), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
        .key_down(kd0), .last_change(lc0), .been_ready(br0), .seq_abort(ab0)
    );

    ps2_scan_decoder #(.TIMEOUT_CYCLES(TO), .REPEAT_EN(1'b1), .TO_W(5)) dut1 (
        .clk(clk), .RST(RST), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
        .key_down(kd1), .last_change(lc1), .been_ready(br1), .seq_abort(ab1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = repeat suppressed, 1 = repeat enabled
    logic [511:0] m_held [2];
    logic [8:0]   m_last [2];
    logic         m_rdy  [2];
    logic         m_abort;
    bit           m_ext, m_brk;
    int           m_skip, m_idle;

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_held[r] = '0;
            m_last[r] = '0;
            m_rdy[r]  = 1'b0;
        end
        m_abort = 1'b0;
        m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
    endtask

    task automatic model_key(input bit brk, input logic [8:0] k);
        for (int r = 0; r < 2; r++) begin
            if (brk) begin
                m_held[r][k] = 1'b0; m_last[r] = k; m_rdy[r] = 1'b1;
            end else if (!m_held[r][k] || r == 1) begin
                m_held[r][k] = 1'b1; m_last[r] = k; m_rdy[r] = 1'b1;
            end
        end
    endtask

    task automatic model_step(input bit v, input bit e, input logic [7:0] b);
        bit in_seq;
        in_seq = m_ext || m_brk || (m_skip > 0);
        m_rdy[0] = 1'b0; m_rdy[1] = 1'b0; m_abort = 1'b0;
        if (e) begin
            m_abort = in_seq;
            m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
        end else if (v) begin
            m_idle = 0;
            if (m_skip > 0) begin
                m_skip--;
            end else if (m_brk) begin
                model_key(1, {m_ext, b});
                m_ext = 0; m_brk = 0;
            end else if (m_ext) begin
                if (b == 8'hF0) m_brk = 1;
                else begin
                    if (b != 8'h12 && b != 8'h59) model_key(0, {1'b1, b});
                    m_ext = 0;
                end
            end else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE1) m_skip = 7;
            else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}))
                model_key(0, {1'b0, b});
        end else if (in_seq) begin
            if (m_idle == TO - 1) begin
                m_abort = 1'b1;
                m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("kd0", kd0, m_held[0]);
        check("kd1", kd1, m_held[1]);
        check("last0", {503'd0, lc0}, {503'd0, m_last[0]});
        check("last1", {503'd0, lc1}, {503'd0, m_last[1]});
        check("ready0", {511'd0, br0}, {511'd0, m_rdy[0]});
        check("ready1", {511'd0, br1}, {511'd0, m_rdy[1]});
        check("abort0", {511'd0, ab0}, {511'd0, m_abort});
        check("abort1", {511'd0, ab1}, {511'd0, m_abort});
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge
    task automatic step(input bit v, input bit e, input logic [7:0] b);
        @(negedge clk);
        rx_valid = v; rx_err = e; rx_byte = b;
        @(posedge clk);
        #1;
        model_step(v, e, b);
        check_all();
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] b;
        case ($urandom_range(0, 11))
            0: b = 8'hE0;
            1: b = 8'hF0;
            2: b = 8'hE1;
            3: b = 8'h12;
            4: b = 8'hAA;
            5: b = 8'hFA;
            6: b = 8'h16;
            7: b = 8'h1E;
            8: b = 8'h70;
            9: b = 8'h25;
            default: b = 8'($urandom_range(0, 255));
        endcase
        return b;
    endfunction

    typedef struct {
        bit         v;
        bit         e;
        logic [7:0] b;
        bit         rdy;
        bit         abt;
        logic [8:0] last;
        logic [8:0] probe;
        bit         pval;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int cnt0, cnt1, exp0, aborts;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_kd0", kd0, 512'd0);
        check("reset_kd1", kd1, 512'd0);
        check("reset_last", {503'd0, lc0}, 512'd0);
        check("reset_ready", {511'd0, br0}, 512'd0);
        check("reset_abort", {511'd0, ab0}, 512'd0);
        @(negedge clk);
        RST = 1'b0;

        // Directed vectors; expectations refer to the REPEAT_EN=0 instance
        //                 v  e  byte   rdy abt last    probe   pval
        tbl.push_back('{1, 0, 8'h16, 1, 0, 9'h016, 9'h016, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 9'h016, 9'h016, 1});
        tbl.push_back('{1, 0, 8'hF0, 0, 0, 9'h016, 9'h016, 1});
        tbl.push_back('{1, 0, 8'h16, 1, 0, 9'h016, 9'h016, 0});
        tbl.push_back('{1, 0, 8'hE0, 0, 0, 9'h016, 9'h170, 0});
        tbl.push_back('{1, 0, 8'h70, 1, 0, 9'h170, 9'h170, 1});
        tbl.push_back('{1, 0, 8'hE0, 0, 0, 9'h170, 9'h070, 0});
        tbl.push_back('{1, 0, 8'hF0, 0, 0, 9'h170, 9'h170, 1});
        tbl.push_back('{1, 0, 8'h70, 1, 0, 9'h170, 9'h170, 0});
        tbl.push_back('{1, 0, 8'hE1, 0, 0, 9'h170, 9'h045, 0});
        tbl.push_back('{1, 0, 8'h14, 0, 0, 9'h170, 9'h014, 0});
        tbl.push_back('{1, 0, 8'h77, 0, 0, 9'h170, 9'h077, 0});
        tbl.push_back('{1, 0, 8'hE1, 0, 0, 9'h170, 9'h014, 0});
        tbl.push_back('{1, 0, 8'hF0, 0, 0, 9'h170, 9'h014, 0});
        tbl.push_back('{1, 0, 8'h14, 0, 0, 9'h170, 9'h014, 0});
        tbl.push_back('{1, 0, 8'hF0, 0, 0, 9'h170, 9'h077, 0});
        tbl.push_back('{1, 0, 8'h77, 0, 0, 9'h170, 9'h077, 0});
        tbl.push_back('{1, 0, 8'h45, 1, 0, 9'h045, 9'h045, 1});
        tbl.push_back('{1, 0, 8'h1E, 1, 0, 9'h01E, 9'h01E, 1});
        tbl.push_back('{1, 0, 8'h1E, 0, 0, 9'h01E, 9'h01E, 1});
        tbl.push_back('{1, 0, 8'h1E, 0, 0, 9'h01E, 9'h01E, 1});
        tbl.push_back('{1, 0, 8'hF0, 0, 0, 9'h01E, 9'h03D, 0});
        tbl.push_back('{0, 1, 8'h3D, 0, 1, 9'h01E, 9'h03D, 0});
        tbl.push_back('{1, 0, 8'h3D, 1, 0, 9'h03D, 9'h03D, 1});
        tbl.push_back('{1, 0, 8'hAA, 0, 0, 9'h03D, 9'h0AA, 0});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 9'h03D, 9'h000, 0});

        cnt0 = 0; cnt1 = 0; exp0 = 0;
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].e, tbl[i].b);
            check("tbl_ready", {511'd0, br0}, {511'd0, tbl[i].rdy});
            check("tbl_abort", {511'd0, ab0}, {511'd0, tbl[i].abt});
            check("tbl_last", {503'd0, lc0}, {503'd0, tbl[i].last});
            check("tbl_probe", {511'd0, kd0[tbl[i].probe]}, {511'd0, tbl[i].pval});
            cnt0 += int'(br0);
            cnt1 += int'(br1);
            exp0 += int'(tbl[i].rdy);
        end
        check("pulses_rep0", 512'(cnt0), 512'(exp0));
        check("pulses_rep1", 512'(cnt1), 512'(exp0 + 2));

        // Timeout: E0 then TO idle clocks -> one abort, next byte is a plain make
        step(1, 0, 8'hE0);
        aborts = 0;
        for (int i = 0; i < int'(TO); i++) begin
            step(0, 0, 8'h00);
            aborts += int'(ab0);
        end
        check("to_abort_count", 512'(aborts), 512'd1);
        step(1, 0, 8'h25);
        check("to_make_plain", {511'd0, kd0[9'h025]}, 512'd1);
        check("to_no_ext", {511'd0, kd0[9'h125]}, 512'd0);

        // Byte landing on the expiry cycle wins
        step(1, 0, 8'hE0);
        aborts = 0;
        for (int i = 0; i < int'(TO) - 1; i++) begin
            step(0, 0, 8'h00);
            aborts += int'(ab0);
        end
        step(1, 0, 8'h25);
        aborts += int'(ab0);
        check("expiry_no_abort", 512'(aborts), 512'd0);
        check("expiry_ext_make", {511'd0, kd0[9'h125]}, 512'd1);
        step(0, 0, 8'h00);
        check("expiry_no_late_abort", {511'd0, ab0}, 512'd0);

        // Async reset in the middle of E0 F0
        step(1, 0, 8'hE0);
        step(1, 0, 8'hF0);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("async_kd0", kd0, 512'd0);
        check("async_kd1", kd1, 512'd0);
        check("async_last", {503'd0, lc0}, 512'd0);
        check("async_ready", {511'd0, br0}, 512'd0);
        check("async_abort", {511'd0, ab0}, 512'd0);
        model_reset();
        @(negedge clk);
        RST = 1'b0;
        step(1, 0, 8'h16);
        check("post_reset_make", {511'd0, kd0[9'h016]}, 512'd1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                step(1, 0, pick_byte());
            end else if (r == 6) begin
                step(1'($urandom_range(0, 1)), 1, pick_byte());
            end else if (r == 7) begin
                repeat ($urandom_range(1, TO + 3)) step(0, 0, 8'h00);
            end else begin
                step(0, 0, 8'h00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
